// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline types, widths and position pack/unpack helpers.
// Positions are packed {x,y} with x in the most significant bits.
package gfx_pkg;

   typedef enum logic [2:0] {
      SHP_LINE   = 3'd0,
      SHP_TRI    = 3'd1,
      SHP_CIRCLE = 3'd2,
      SHP_RECT   = 3'd3
   } shape_e;

   localparam logic SEG_LINE = 1'b0;
   localparam logic SEG_CIRC = 1'b1;

   localparam int DEF_X_W     = 10;
   localparam int DEF_Y_W     = 9;
   localparam int DEF_COLOR_W = 16;

   // Helpers work on a 32-bit container; callers cast to their own widths.
   function automatic logic [31:0] pos_pack(
      input logic [15:0] x,
      input logic [15:0] y,
      input int unsigned yw
   );
      return (32'(x) << yw) | 32'(y);
   endfunction

   function automatic logic [15:0] pos_x(
      input logic [31:0] p,
      input int unsigned yw
   );
      return 16'(p >> yw);
   endfunction

   function automatic logic [15:0] pos_y(
      input logic [31:0] p,
      input int unsigned yw
   );
      return 16'(p & ((32'd1 << yw) - 32'd1));
   endfunction

endpackage

// File: rtl/shape_segmenter_if.sv
// Handshake bundles: decoded draw command in, primitive out.
// Signal names match the segmenter's external port names.
interface gfx_cmd_if
   import gfx_pkg::*;
#(
   parameter int X_W     = DEF_X_W,
   parameter int Y_W     = DEF_Y_W,
   parameter int COLOR_W = DEF_COLOR_W
);
   localparam int POS_W = X_W + Y_W;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [2:0]         cmd_type;
   logic [COLOR_W-1:0] cmd_color;
   logic [POS_W-1:0]   cmd_p1;
   logic [POS_W-1:0]   cmd_p2;
   logic [POS_W-1:0]   cmd_p3;

   modport master (
      output cmd_valid, cmd_type, cmd_color,
      output cmd_p1, cmd_p2, cmd_p3,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_color,
      input  cmd_p1, cmd_p2, cmd_p3,
      output cmd_ready
   );
endinterface

interface gfx_seg_if
   import gfx_pkg::*;
#(
   parameter int X_W     = DEF_X_W,
   parameter int Y_W     = DEF_Y_W,
   parameter int COLOR_W = DEF_COLOR_W
);
   localparam int POS_W = X_W + Y_W;

   logic               seg_valid;
   logic               seg_ready;
   logic               seg_kind;
   logic [POS_W-1:0]   seg_start;
   logic [POS_W-1:0]   seg_end;
   logic [COLOR_W-1:0] seg_color;
   logic               seg_last;

   modport master (
      output seg_valid, seg_kind, seg_start,
      output seg_end, seg_color, seg_last,
      input  seg_ready
   );

   modport slave (
      input  seg_valid, seg_kind, seg_start,
      input  seg_end, seg_color, seg_last,
      output seg_ready
   );
endinterface

// File: rtl/shape_segmenter_select.sv
// Maps a command type, primitive index and positions A/B/C
// to one primitive: {kind, start, end, last}.
module segment_select
   import gfx_pkg::*;
#(
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W,
   localparam int POS_W = X_W + Y_W
) (
   input  logic [2:0]       typ,
   input  logic [1:0]       idx,
   input  logic [POS_W-1:0] p1,
   input  logic [POS_W-1:0] p2,
   input  logic [POS_W-1:0] p3,
   output logic             kind,
   output logic [POS_W-1:0] start_pos,
   output logic [POS_W-1:0] end_pos,
   output logic             last
);

   function automatic logic [POS_W-1:0] mk(
      input logic [X_W-1:0] x,
      input logic [Y_W-1:0] y
   );
      return POS_W'(pos_pack(16'(x), 16'(y), Y_W));
   endfunction

   logic [X_W-1:0]   x1, x2;
   logic [Y_W-1:0]   y1, y2;
   logic [POS_W-1:0] c11, c21, c22, c12;

   assign x1  = X_W'(pos_x(32'(p1), Y_W));
   assign y1  = Y_W'(pos_y(32'(p1), Y_W));
   assign x2  = X_W'(pos_x(32'(p2), Y_W));
   assign y2  = Y_W'(pos_y(32'(p2), Y_W));
   assign c11 = mk(x1, y1);
   assign c21 = mk(x2, y1);
   assign c22 = mk(x2, y2);
   assign c12 = mk(x1, y2);

   always_comb begin
      kind      = SEG_LINE;
      start_pos = p1;
      end_pos   = p2;
      last      = 1'b1;
      unique case (typ)
         SHP_TRI: begin
            last = (idx == 2'd2);
            unique case (1'b1)
               (idx == 2'd0): begin
                  start_pos = p1;
                  end_pos   = p2;
               end
               (idx == 2'd1): begin
                  start_pos = p2;
                  end_pos   = p3;
               end
               default: begin
                  start_pos = p1;
                  end_pos   = p3;
               end
            endcase
         end
         SHP_CIRCLE: begin
            kind      = SEG_CIRC;
            start_pos = p2;
            end_pos   = p3;
         end
         SHP_RECT: begin
            last = (idx == 2'd3);
            unique case (1'b1)
               (idx == 2'd0): begin
                  start_pos = c11;
                  end_pos   = c21;
               end
               (idx == 2'd1): begin
                  start_pos = c21;
                  end_pos   = c22;
               end
               (idx == 2'd2): begin
                  start_pos = c22;
                  end_pos   = c12;
               end
               default: begin
                  start_pos = c12;
                  end_pos   = c11;
               end
            endcase
         end
         default: begin
            start_pos = p1;
            end_pos   = p2;
         end
      endcase
   end

endmodule

// File: rtl/shape_segmenter.sv
// Sequential draw-command segmenter: one command in, its line or
// circle primitives out one per handshake, all outputs registered.
module shape_segmenter
   import gfx_pkg::*;
#(
   parameter int X_W     = DEF_X_W,
   parameter int Y_W     = DEF_Y_W,
   parameter int COLOR_W = DEF_COLOR_W,
   localparam int POS_W  = X_W + Y_W
) (
   input  logic        clk,
   input  logic        n_rst,
   gfx_cmd_if.slave    cmd,
   gfx_seg_if.master   seg,
   output logic        busy,
   output logic        cmd_err
);

   typedef enum logic {IDLE, EMIT} state_e;

   state_e             state_q, state_d;
   logic [2:0]         type_q;
   logic [COLOR_W-1:0] color_q;
   logic [POS_W-1:0]   p1_q, p2_q, p3_q;
   logic [1:0]         idx_q;
   logic               kind_q, last_q, err_q;
   logic [POS_W-1:0]   start_q, end_q;

   logic               accept, legal, fire, advance, load;
   logic [2:0]         sel_type;
   logic [1:0]         sel_idx;
   logic [POS_W-1:0]   sel_p1, sel_p2, sel_p3;
   logic               sel_kind, sel_last;
   logic [POS_W-1:0]   sel_start, sel_end;

   assign accept  = (state_q == IDLE) && cmd.cmd_valid;
   assign legal   = !cmd.cmd_type[2];
   assign fire    = (state_q == EMIT) && seg.seg_ready;
   assign advance = fire && !last_q;
   assign load    = (accept && legal) || advance;

   // Look one primitive ahead so the output registers load on the
   // accepting edge and on each non-final handshake.
   assign sel_type = (state_q == IDLE) ? cmd.cmd_type : type_q;
   assign sel_p1   = (state_q == IDLE) ? cmd.cmd_p1 : p1_q;
   assign sel_p2   = (state_q == IDLE) ? cmd.cmd_p2 : p2_q;
   assign sel_p3   = (state_q == IDLE) ? cmd.cmd_p3 : p3_q;
   assign sel_idx  = (state_q == IDLE) ? 2'd0 : idx_q + 2'd1;

   segment_select #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_select (
      .typ       (sel_type),
      .idx       (sel_idx),
      .p1        (sel_p1),
      .p2        (sel_p2),
      .p3        (sel_p3),
      .kind      (sel_kind),
      .start_pos (sel_start),
      .end_pos   (sel_end),
      .last      (sel_last)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept && legal) state_d = EMIT;
         EMIT: if (fire && last_q)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         type_q  <= '0;
         color_q <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         p3_q    <= '0;
         idx_q   <= '0;
         kind_q  <= 1'b0;
         start_q <= '0;
         end_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= accept && !legal;
         if (accept) begin
            type_q  <= cmd.cmd_type;
            color_q <= cmd.cmd_color;
            p1_q    <= cmd.cmd_p1;
            p2_q    <= cmd.cmd_p2;
            p3_q    <= cmd.cmd_p3;
            idx_q   <= '0;
         end else if (advance) begin
            idx_q <= idx_q + 2'd1;
         end
         if (load) begin
            kind_q  <= sel_kind;
            start_q <= sel_start;
            end_q   <= sel_end;
            last_q  <= sel_last;
         end
      end
   end

   assign cmd.cmd_ready = (state_q == IDLE);
   assign seg.seg_valid = (state_q == EMIT);
   assign seg.seg_kind  = kind_q;
   assign seg.seg_start = start_q;
   assign seg.seg_end   = end_q;
   assign seg.seg_color = color_q;
   assign seg.seg_last  = last_q;
   assign busy          = (state_q == EMIT);
   assign cmd_err       = err_q;

endmodule

// File: tb/tb_shape_segmenter.sv
// Table-driven bench for shape_segmenter with a primitive scoreboard.
// Hand-written sequences cover illegal types and reset mid-command.
module tb_shape_segmenter;

   localparam int X_W     = 10;
   localparam int Y_W     = 9;
   localparam int COLOR_W = 16;
   localparam int POS_W   = X_W + Y_W;

   logic clk = 1'b0;
   logic n_rst;
   logic busy, cmd_err;

   always #5 clk = ~clk;

   gfx_cmd_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) cmd_bus ();
   gfx_seg_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) seg_bus ();

   shape_segmenter #(
      .X_W     (X_W),
      .Y_W     (Y_W),
      .COLOR_W (COLOR_W)
   ) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .cmd     (cmd_bus),
      .seg     (seg_bus),
      .busy    (busy),
      .cmd_err (cmd_err)
   );

   typedef struct {
      logic               kind;
      logic [POS_W-1:0]   st;
      logic [POS_W-1:0]   en;
      logic               last;
      logic [COLOR_W-1:0] color;
   } exp_t;

   typedef struct {
      logic [2:0]                  typ;
      logic [COLOR_W-1:0]          color;
      logic [POS_W-1:0]            p1, p2, p3;
      int                          n;
      logic [3:0]                  kind;
      logic [3:0][POS_W-1:0]       st;
      logic [3:0][POS_W-1:0]       en;
      logic [7:0]                  rdy;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [POS_W-1:0] pp(input int x, input int y);
      return {x[X_W-1:0], y[Y_W-1:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_ready"}, 32'(cmd_bus.cmd_ready), 1);
      chk({pfx, "_valid"}, 32'(seg_bus.seg_valid), 0);
      chk({pfx, "_kind"},  32'(seg_bus.seg_kind), 0);
      chk({pfx, "_start"}, 32'(seg_bus.seg_start), 0);
      chk({pfx, "_end"},   32'(seg_bus.seg_end), 0);
      chk({pfx, "_color"}, 32'(seg_bus.seg_color), 0);
      chk({pfx, "_last"},  32'(seg_bus.seg_last), 0);
      chk({pfx, "_busy"},  32'(busy), 0);
      chk({pfx, "_err"},   32'(cmd_err), 0);
   endtask

   task automatic drive_cmd(input logic [2:0] typ,
                            input logic [COLOR_W-1:0] color,
                            input logic [POS_W-1:0] p1,
                            input logic [POS_W-1:0] p2,
                            input logic [POS_W-1:0] p3);
      @(negedge clk);
      cmd_bus.cmd_type  = typ;
      cmd_bus.cmd_color = color;
      cmd_bus.cmd_p1    = p1;
      cmd_bus.cmd_p2    = p2;
      cmd_bus.cmd_p3    = p3;
      cmd_bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_bus.cmd_valid = 1'b0;
   endtask

   task automatic run(input vec_t v, input string nm);
      exp_t e;
      int   k;
      for (int i = 0; i < v.n; i++) begin
         e.kind  = v.kind[i];
         e.st    = v.st[i];
         e.en    = v.en[i];
         e.last  = (i == v.n - 1);
         e.color = v.color;
         sb.push_back(e);
      end
      @(negedge clk);
      chk({nm, "_idle_ready"}, 32'(cmd_bus.cmd_ready), 1);
      drive_cmd(v.typ, v.color, v.p1, v.p2, v.p3);
      k = 0;
      while (sb.size() > 0 && k < 40) begin
         @(negedge clk);
         seg_bus.seg_ready = v.rdy[k % 8];
         e = sb[0];
         chk({nm, "_valid"}, 32'(seg_bus.seg_valid), 1);
         chk({nm, "_busy"},  32'(busy), 1);
         chk({nm, "_ready"}, 32'(cmd_bus.cmd_ready), 0);
         chk({nm, "_kind"},  32'(seg_bus.seg_kind), 32'(e.kind));
         chk({nm, "_start"}, 32'(seg_bus.seg_start), 32'(e.st));
         chk({nm, "_end"},   32'(seg_bus.seg_end), 32'(e.en));
         chk({nm, "_last"},  32'(seg_bus.seg_last), 32'(e.last));
         chk({nm, "_color"}, 32'(seg_bus.seg_color), 32'(e.color));
         if (seg_bus.seg_valid && seg_bus.seg_ready) void'(sb.pop_front());
         k++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=%0d required=0 pending",
                  nm, sb.size());
         sb.delete();
      end
      @(negedge clk);
      seg_bus.seg_ready = 1'b0;
      chk({nm, "_done_valid"}, 32'(seg_bus.seg_valid), 0);
      chk({nm, "_done_ready"}, 32'(cmd_bus.cmd_ready), 1);
      chk({nm, "_done_busy"},  32'(busy), 0);
   endtask

   initial begin
      vecs[0] = '{typ: 3'd0, color: 16'h1234,
                  p1: pp(5, 7), p2: pp(100, 200), p3: '0, n: 1,
                  kind: 4'b0000, st: '0, en: '0, rdy: 8'hFF};
      vecs[0].st[0] = pp(5, 7);
      vecs[0].en[0] = pp(100, 200);

      vecs[1] = '{typ: 3'd1, color: 16'h07E0,
                  p1: pp(0, 0), p2: pp(10, 0), p3: pp(0, 10), n: 3,
                  kind: 4'b0000, st: '0, en: '0, rdy: 8'b01010101};
      vecs[1].st[0] = pp(0, 0);   vecs[1].en[0] = pp(10, 0);
      vecs[1].st[1] = pp(10, 0);  vecs[1].en[1] = pp(0, 10);
      vecs[1].st[2] = pp(0, 0);   vecs[1].en[2] = pp(0, 10);

      vecs[2] = '{typ: 3'd3, color: 16'h001F,
                  p1: pp(3, 4), p2: pp(50, 60), p3: pp(1, 1), n: 4,
                  kind: 4'b0000, st: '0, en: '0, rdy: 8'hFF};
      vecs[2].st[0] = pp(3, 4);   vecs[2].en[0] = pp(50, 4);
      vecs[2].st[1] = pp(50, 4);  vecs[2].en[1] = pp(50, 60);
      vecs[2].st[2] = pp(50, 60); vecs[2].en[2] = pp(3, 60);
      vecs[2].st[3] = pp(3, 60);  vecs[2].en[3] = pp(3, 4);

      vecs[3] = '{typ: 3'd2, color: 16'hF800,
                  p1: pp(7, 7), p2: pp(320, 240), p3: 19'd25, n: 1,
                  kind: 4'b0001, st: '0, en: '0, rdy: 8'b11111110};
      vecs[3].st[0] = pp(320, 240);
      vecs[3].en[0] = 19'd25;

      vecs[4] = '{typ: 3'd1, color: 16'hAAAA,
                  p1: pp(9, 9), p2: pp(9, 9), p3: pp(9, 9), n: 3,
                  kind: 4'b0000, st: '0, en: '0, rdy: 8'b11001100};
      for (int i = 0; i < 3; i++) begin
         vecs[4].st[i] = pp(9, 9);
         vecs[4].en[i] = pp(9, 9);
      end

      vecs[5] = '{typ: 3'd3, color: 16'h5555,
                  p1: pp(7, 2), p2: pp(7, 30), p3: '0, n: 4,
                  kind: 4'b0000, st: '0, en: '0, rdy: 8'b10110111};
      vecs[5].st[0] = pp(7, 2);   vecs[5].en[0] = pp(7, 2);
      vecs[5].st[1] = pp(7, 2);   vecs[5].en[1] = pp(7, 30);
      vecs[5].st[2] = pp(7, 30);  vecs[5].en[2] = pp(7, 30);
      vecs[5].st[3] = pp(7, 30);  vecs[5].en[3] = pp(7, 2);

      n_rst             = 1'b0;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_type  = '0;
      cmd_bus.cmd_color = '0;
      cmd_bus.cmd_p1    = '0;
      cmd_bus.cmd_p2    = '0;
      cmd_bus.cmd_p3    = '0;
      seg_bus.seg_ready = 1'b0;
      #12;
      chk_reset("rst");
      @(negedge clk);
      n_rst = 1'b1;

      for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

      drive_cmd(3'd6, 16'hFFFF, pp(1, 2), pp(3, 4), pp(5, 6));
      @(negedge clk);
      chk("ill_err",   32'(cmd_err), 1);
      chk("ill_valid", 32'(seg_bus.seg_valid), 0);
      chk("ill_ready", 32'(cmd_bus.cmd_ready), 1);
      @(negedge clk);
      chk("ill_err_end",   32'(cmd_err), 0);
      chk("ill_valid_end", 32'(seg_bus.seg_valid), 0);

      drive_cmd(3'd1, 16'h1111, pp(0, 0), pp(10, 0), pp(0, 10));
      @(negedge clk);
      seg_bus.seg_ready = 1'b1;
      chk("ar_first", 32'(seg_bus.seg_start), 32'(pp(0, 0)));
      @(negedge clk);
      seg_bus.seg_ready = 1'b0;
      chk("ar_second", 32'(seg_bus.seg_start), 32'(pp(10, 0)));
      chk("ar_valid",  32'(seg_bus.seg_valid), 1);
      #2 n_rst = 1'b0;
      #1 chk_reset("ar");
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      chk("ar_idle_valid", 32'(seg_bus.seg_valid), 0);
      run(vecs[0], "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
